vector_register_file_mt: RTL

//  Multi-thread vector register file: NUM_THREADS x NUM_REGS vectors of LANES x LANE_WIDTH bits.
//  Two read ports (decode stage) and one lane-masked write port (writeback stage).

---
 rtl/vector_register_file_mt.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vector_register_file_mt.sv
// Multi-thread vector register file with a hardware clear after reset.
// Storage holds NUM_THREADS x NUM_REGS entries of LANES x LANE_WIDTH bits.
// Each lane is written independently under a per-lane mask.
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   rf_ready                    high once every entry has been cleared
//   ds_thread_idx               read thread, shared by both read ports
//   ds_vector_sel1/2            read register selects
//   ds_read_en                  capture new read data at this edge
//   rf_vector_value1/2          registered read data, lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   wb_thread_idx, wb_writeback_reg, wb_writeback_value, wb_writeback_mask,
//   wb_enable_vector_writeback  lane-masked write port
module vector_register_file_mt #(
  parameter int unsigned LANES       = 16,
  parameter int unsigned LANE_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 32,
  parameter int unsigned NUM_THREADS = 4,
  parameter bit          BYPASS      = 1'b1,
  localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int unsigned VB = LANES * LANE_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rf_ready,
  input  logic [TW-1:0] ds_thread_idx,
  input  logic [RW-1:0] ds_vector_sel1,
  input  logic [RW-1:0] ds_vector_sel2,
  input  logic          ds_read_en,
  output logic [VB-1:0] rf_vector_value1,
  output logic [VB-1:0] rf_vector_value2,
  input  logic [TW-1:0] wb_thread_idx,
  input  logic [RW-1:0] wb_writeback_reg,
  input  logic [VB-1:0] wb_writeback_value,
  input  logic [LANES-1:0] wb_writeback_mask,
  input  logic          wb_enable_vector_writeback
);

  localparam int unsigned ENTRIES = NUM_THREADS * NUM_REGS;
  localparam int unsigned EW      = $clog2(ENTRIES);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t        state;
  logic [EW-1:0] cnt;
  logic [VB-1:0] mem [ENTRIES];

  logic          ok1, ok2, okw, we;
  logic [EW-1:0] a1, a2, aw;
  logic [VB-1:0] rd1, rd2;

  // Linear entry index: thread-major, register-minor.
  function automatic logic [EW-1:0] entry_of(input logic [TW-1:0] t, input logic [RW-1:0] r);
    return EW'(t) * EW'(NUM_REGS) + EW'(r);
  endfunction

  // Zero-extended compares keep the range check meaningful for non-power-of-2 sizes.
  function automatic logic sel_ok(input logic [TW-1:0] t, input logic [RW-1:0] r);
    return ({1'b0, t} < (TW+1)'(NUM_THREADS)) && ({1'b0, r} < (RW+1)'(NUM_REGS));
  endfunction

  assign a1  = entry_of(ds_thread_idx, ds_vector_sel1);
  assign a2  = entry_of(ds_thread_idx, ds_vector_sel2);
  assign aw  = entry_of(wb_thread_idx, wb_writeback_reg);
  assign ok1 = sel_ok(ds_thread_idx, ds_vector_sel1);
  assign ok2 = sel_ok(ds_thread_idx, ds_vector_sel2);
  assign okw = sel_ok(wb_thread_idx, wb_writeback_reg);
  assign we  = wb_enable_vector_writeback & rf_ready & okw;

  // Read mux with optional same-cycle forwarding of the masked write lanes.
  always_comb begin
    rd1 = ok1 ? mem[a1] : '0;
    rd2 = ok2 ? mem[a2] : '0;
    if (BYPASS) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (we && wb_writeback_mask[i] && ok1 && (a1 == aw))
          rd1[i*LANE_WIDTH +: LANE_WIDTH] = wb_writeback_value[i*LANE_WIDTH +: LANE_WIDTH];
        if (we && wb_writeback_mask[i] && ok2 && (a2 == aw))
          rd2[i*LANE_WIDTH +: LANE_WIDTH] = wb_writeback_value[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Storage: cleared one entry per cycle while clearing, lane-masked writes once ready.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (wb_writeback_mask[i])
          mem[aw][i*LANE_WIDTH +: LANE_WIDTH] <= wb_writeback_value[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Clear sequencer and registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_CLEAR;
      cnt              <= '0;
      rf_ready         <= 1'b0;
      rf_vector_value1 <= '0;
      rf_vector_value2 <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt              <= cnt + EW'(1);
          rf_vector_value1 <= '0;
          rf_vector_value2 <= '0;
          if (cnt == EW'(ENTRIES - 1)) begin
            state    <= S_READY;
            rf_ready <= 1'b1;
          end
        end
        S_READY: begin
          if (ds_read_en) begin
            rf_vector_value1 <= rd1;
            rf_vector_value2 <= rd2;
          end
        end
        default: begin
          state    <= S_CLEAR;
          cnt      <= '0;
          rf_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
